// File: rtl/if_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_loader_ctrl
// Purpose  : Debug-side sequencer for the instruction-fetch stage. Builds
//            32-bit instruction words from a byte stream (MSB first) and
//            writes them into instruction memory. Once loaded, it drives the
//            IF step enable in continuous-run or single-step mode until the
//            HALT instruction is fetched.
// Ports    : i_clk, i_reset (async, active-low)
//            i_rx_data/i_rx_valid     - received byte and its 1-cycle strobe
//            i_instruction            - instruction currently fetched by IF
//            o_instruction_address    - byte address of the memory write
//            o_instruction            - assembled instruction word
//            o_flag_write_intruc      - 1-cycle instruction-memory write strobe
//            o_step                   - IF/pipeline advance enable
//            o_halted                 - HALT fetched, execution finished
//            o_load_error             - sticky, load overran memory w/o HALT
//            o_state                  - registered FSM state for readback
// Revision : 1.0 - initial release
// ============================================================================
module if_loader_ctrl #(
  parameter int                   BITS_SIZE  = 32,
  parameter int                   SIZE_TOTAL = 256,
  parameter logic [BITS_SIZE-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  input  logic [BITS_SIZE-1:0] i_instruction,
  output logic [BITS_SIZE-1:0] o_instruction_address,
  output logic [BITS_SIZE-1:0] o_instruction,
  output logic                 o_flag_write_intruc,
  output logic                 o_step,
  output logic                 o_halted,
  output logic                 o_load_error,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_RUN        = 3'd2,
    S_STEP_WAIT  = 3'd3,
    S_STEP_PULSE = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [7:0] c_CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] c_CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] c_CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] c_CMD_NEXT = 8'h4E;  // 'N'
  localparam logic [7:0] c_CMD_EXIT = 8'h45;  // 'E'

  localparam logic [BITS_SIZE-1:0] c_WORD_BYTES = BITS_SIZE'(4);
  localparam logic [BITS_SIZE-1:0] c_LAST_ADDR  = BITS_SIZE'(SIZE_TOTAL - 4);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_step;

  // First three bytes of the word under assembly; the fourth byte completes
  // the word directly into the output register.
  logic [BITS_SIZE-9:0]   r_word;
  logic [1:0]             r_cnt;
  logic [BITS_SIZE-1:0]   r_addr;
  logic [BITS_SIZE-1:0]   r_out_word;
  logic [BITS_SIZE-1:0]   r_out_addr;
  logic                   r_wr;
  logic                   r_err;

  logic [BITS_SIZE-1:0]   w_word_next;
  logic                   w_load_cmd;
  logic                   w_fetch_halt;
  logic                   w_wr_halt;
  logic                   w_wr_last;

  assign w_word_next  = {r_word, i_rx_data};
  assign w_fetch_halt = (i_instruction == HALT_INSTR);
  assign w_wr_halt    = (r_out_word == HALT_INSTR);
  assign w_wr_last    = (r_out_addr == c_LAST_ADDR);
  assign w_load_cmd   = i_rx_valid && (i_rx_data == c_CMD_LOAD) &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and step enable
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == c_CMD_LOAD)      w_state_next = S_LOAD;
          else if (i_rx_data == c_CMD_RUN)  w_state_next = S_RUN;
          else if (i_rx_data == c_CMD_STEP) w_state_next = S_STEP_WAIT;
        end
      end
      S_LOAD: begin
        // The load ends in the strobe cycle of either a HALT word or the
        // word occupying the last memory slot.
        if (r_wr && (w_wr_halt || w_wr_last)) w_state_next = S_IDLE;
      end
      S_RUN: begin
        // Gate the step in the same cycle HALT appears so the pipeline never
        // advances past it.
        w_step = !w_fetch_halt;
        if (w_fetch_halt) w_state_next = S_DONE;
      end
      S_STEP_WAIT: begin
        if (w_fetch_halt) begin
          w_state_next = S_DONE;
        end else if (i_rx_valid) begin
          if (i_rx_data == c_CMD_NEXT)      w_state_next = S_STEP_PULSE;
          else if (i_rx_data == c_CMD_EXIT) w_state_next = S_IDLE;
        end
      end
      S_STEP_PULSE: begin
        w_step       = 1'b1;
        w_state_next = S_STEP_WAIT;
      end
      S_DONE: begin
        if (i_rx_valid && (i_rx_data == c_CMD_LOAD)) w_state_next = S_LOAD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load datapath: byte assembly, write strobe, address and error tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_word     <= '0;
      r_cnt      <= 2'd0;
      r_addr     <= '0;
      r_out_word <= '0;
      r_out_addr <= '0;
      r_wr       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (w_load_cmd) begin
        r_word <= '0;
        r_cnt  <= 2'd0;
        r_addr <= '0;
        r_err  <= 1'b0;
      end else if (r_state == S_LOAD) begin
        // Bytes are accepted in the strobe cycle too, as the start of the
        // next word, so a back-to-back stream loses nothing.
        if (i_rx_valid) begin
          r_word <= w_word_next[BITS_SIZE-9:0];
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_wr       <= 1'b1;
            r_out_word <= w_word_next;
            r_out_addr <= r_addr;
          end
        end
        if (r_wr) begin
          if (!w_wr_halt && w_wr_last) begin
            r_err <= 1'b1;
          end else begin
            r_addr <= r_addr + c_WORD_BYTES;
          end
        end
      end
    end
  end

  assign o_instruction_address = r_out_addr;
  assign o_instruction         = r_out_word;
  assign o_flag_write_intruc   = r_wr;
  assign o_step                = w_step;
  assign o_halted              = (r_state == S_DONE);
  assign o_load_error          = r_err;
  assign o_state               = r_state;

endmodule
`default_nettype wire

// File: tb/tb_if_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_loader_ctrl
// Purpose  : Self-checking bench for if_loader_ctrl. Inputs change on the
//            falling clock edge; outputs are sampled 2 ns later, mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] instr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        step;
  logic        halted;
  logic        load_err;
  logic [2:0]  state;

  always #5 clk = ~clk;

  if_loader_ctrl dut (
    .i_clk                 (clk),
    .i_reset               (rst_n),
    .i_rx_data             (rx_data),
    .i_rx_valid            (rx_valid),
    .i_instruction         (instr),
    .o_instruction_address (wr_addr),
    .o_instruction         (wr_data),
    .o_flag_write_intruc   (wr_en),
    .o_step                (step),
    .o_halted              (halted),
    .o_load_error          (load_err),
    .o_state               (state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write-strobe log, sampled on the falling edge.
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        prev_wr = 1'b0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      check("strobe_single_cycle", {31'd0, prev_wr}, 32'd0);
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    prev_wr = (wr_en === 1'b1);
  end

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic [31:0] ins;
    logic [2:0]  st;
    logic        step;
    logic        halted;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [31:0] ins,
                              input logic [2:0] st, input logic stp, input logic h);
    vec_t r;
    r.v = v; r.d = d; r.ins = ins; r.st = st; r.step = stp; r.halted = h;
    return r;
  endfunction

  // All tasks start and end aligned to a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    #1;
    log_addr.delete();
    log_data.delete();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, {29'd0, state}, 32'd0);
    check({tag, "_addr"},  wr_addr, 32'd0);
    check({tag, "_data"},  wr_data, 32'd0);
    check({tag, "_outs"},  {28'd0, wr_en, step, halted, load_err}, 32'd0);
  endtask

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    int pulses;
    // Run-mode table: each row drives inputs for one cycle and lists the
    // outputs expected in that same cycle.
    vecs[0]  = mk(1'b1, 8'h52, 32'h0000_0000, 3'd0, 1'b0, 1'b0);  // 'R' in IDLE
    vecs[1]  = mk(1'b0, 8'h00, 32'h0000_0000, 3'd2, 1'b1, 1'b0);
    vecs[2]  = mk(1'b0, 8'h00, 32'h0000_0000, 3'd2, 1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 8'h4C, 32'h0000_0000, 3'd2, 1'b1, 1'b0);  // 'L' ignored in RUN
    vecs[4]  = mk(1'b0, 8'h00, 32'h0000_0000, 3'd2, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 8'h00, 32'h0000_0000, 3'd2, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 8'h00, 32'hFFFF_FFFF, 3'd2, 1'b0, 1'b0);  // HALT fetched
    vecs[7]  = mk(1'b1, 8'h52, 32'hFFFF_FFFF, 3'd5, 1'b0, 1'b1);  // 'R' in DONE
    vecs[8]  = mk(1'b1, 8'h53, 32'h0000_0000, 3'd5, 1'b0, 1'b1);  // 'S' in DONE
    vecs[9]  = mk(1'b0, 8'h00, 32'h0000_0000, 3'd5, 1'b0, 1'b1);
    vecs[10] = mk(1'b1, 8'h4C, 32'h0000_0000, 3'd5, 1'b0, 1'b1);  // 'L' leaves DONE
    vecs[11] = mk(1'b0, 8'h00, 32'h0000_0000, 3'd1, 1'b0, 1'b0);

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    instr    = 32'h0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Reset in the middle of a word.
    send_byte(8'h4C);
    send_byte(8'h11);
    send_byte(8'h22);
    check("midload_state", {29'd0, state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h33);
    send_byte(8'h44);
    idle(4);
    check("midload_no_strobe", log_addr.size(), 32'd0);
    check("midload_idle", {29'd0, state}, 32'd0);

    // Two words, back to back, the second being HALT.
    clear_log();
    send_byte(8'h4C);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    idle(4);
    check("two_cnt", log_addr.size(), 32'd2);
    if (log_addr.size() == 2) begin
      check("two_addr0", log_addr[0], 32'h0000_0000);
      check("two_data0", log_data[0], 32'h2008_0005);
      check("two_addr1", log_addr[1], 32'h0000_0004);
      check("two_data1", log_data[1], 32'hFFFF_FFFF);
    end
    check("two_state", {29'd0, state}, 32'd0);
    check("two_err", {31'd0, load_err}, 32'd0);
    check("two_hold_addr", wr_addr, 32'h0000_0004);
    check("two_hold_data", wr_data, 32'hFFFF_FFFF);

    // Fill all 64 words without a HALT.
    clear_log();
    send_byte(8'h4C);
    for (int i = 0; i < 256; i++) send_byte(8'h00);
    idle(6);
    check("fill_cnt", log_addr.size(), 32'd64);
    for (int i = 0; i < log_addr.size(); i++) begin
      check("fill_addr", log_addr[i], 32'(i * 4));
      check("fill_data", log_data[i], 32'h0);
    end
    check("fill_err", {31'd0, load_err}, 32'd1);
    check("fill_state", {29'd0, state}, 32'd0);
    check("fill_hold_addr", wr_addr, 32'd252);

    // A new load clears the error flag; end it with a HALT word.
    send_byte(8'h4C);
    check("reload_err_clr", {31'd0, load_err}, 32'd0);
    check("reload_state", {29'd0, state}, 32'd1);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    idle(3);
    check("reload_state_idle", {29'd0, state}, 32'd0);

    // Run-mode table.
    for (int i = 0; i < NV; i++) begin
      rx_valid = vecs[i].v;
      rx_data  = vecs[i].d;
      instr    = vecs[i].ins;
      #2;
      check($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, vecs[i].st});
      check($sformatf("vec%0d_step", i), {31'd0, step}, {31'd0, vecs[i].step});
      check($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].halted});
      @(negedge clk);
    end
    rx_valid = 1'b0;
    instr    = 32'h0;
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    idle(3);
    check("table_exit_idle", {29'd0, state}, 32'd0);

    // Single-step: three 'N' strobes ten cycles apart.
    send_byte(8'h53);
    check("step_wait_state", {29'd0, state}, 32'd3);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h4E);
      #2;
      check("step_pulse_on", {31'd0, step}, 32'd1);
      check("step_pulse_state", {29'd0, state}, 32'd4);
      @(negedge clk);
      for (int c = 0; c < 9; c++) begin
        #2;
        if (step === 1'b1) pulses++;
        @(negedge clk);
      end
    end
    check("step_no_extra", pulses, 32'd0);
    send_byte(8'h45);
    check("step_exit_idle", {29'd0, state}, 32'd0);

    // HALT wins over a simultaneous 'N'.
    send_byte(8'h53);
    rx_valid = 1'b1;
    rx_data  = 8'h4E;
    instr    = 32'hFFFF_FFFF;
    #2;
    check("prio_step_same", {31'd0, step}, 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    #2;
    check("prio_step_next", {31'd0, step}, 32'd0);
    check("prio_state", {29'd0, state}, 32'd5);
    check("prio_halted", {31'd0, halted}, 32'd1);
    @(negedge clk);
    instr = 32'h0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_loader_ctrl.md
Name: if_loader_ctrl

Overview:
Debug-side controller that sequences the instruction-fetch stage. It assembles 32-bit instruction words from a byte stream, such as a UART receiver, and writes them into instruction memory through the IF write port. It then drives the IF/pipeline step enable in continuous-run or single-step mode until the HALT instruction is fetched. It sits between the debug byte interface and the IF stage's `i_step`, `i_instruction_address`, `i_instruction` and `i_flag_write_intruc` inputs.

Parameters:
- BITS_SIZE, 32, instruction and address width.
- SIZE_TOTAL, 256, instruction memory size in bytes (64 words).
- HALT_INSTR, 32'hFFFF_FFFF, encoding that terminates a load and stops execution.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
- i_instruction  in  BITS_SIZE  instruction currently fetched by IF (o_instruction of IF).
- o_instruction_address  out  BITS_SIZE  byte address for an instruction-memory write.
- o_instruction  out  BITS_SIZE  assembled instruction word.
- o_flag_write_intruc  out  1  one-cycle instruction-memory write strobe.
- o_step  out  1  IF/pipeline advance enable.
- o_halted  out  1  HALT has been fetched; execution is finished.
- o_load_error  out  1  sticky; the load overran memory without a HALT word.
- o_state  out  3  current FSM state, for debug readback.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including the byte counter, word shift register and address register.
  - Reset mid-load discards any partial word; no write strobe is emitted.
- State encoding: IDLE=0, LOAD=1, RUN=2, STEP_WAIT=3, STEP_PULSE=4, DONE=5.
- Commands are accepted only on i_rx_valid, in IDLE or DONE:
  - 8'h4C 'L' → LOAD. Clears the address register to 0, the byte counter to 0 and o_load_error.
  - 8'h52 'R' → RUN.
  - 8'h53 'S' → STEP_WAIT.
  - In DONE, 'R' and 'S' are ignored; only 'L' leaves DONE. o_halted clears on 'L'.
  - Any other byte is ignored.
- LOAD:
  - Each valid byte shifts into the word MSB-first: word = {word[23:0], byte}. The byte counter increments modulo 4.
  - On the 4th byte, the next cycle has o_flag_write_intruc=1 for exactly one cycle, with o_instruction = assembled word and o_instruction_address = address register.
  - After the strobe, address += 4.
  - If the written word equals HALT_INSTR → IDLE after the strobe.
  - If the word written at address SIZE_TOTAL-4 is not HALT_INSTR → o_load_error=1, state IDLE, address held.
  - A byte arriving in the strobe cycle is accepted as byte 0 of the next word; there is no dropped byte.
  - Addresses are never written at or above SIZE_TOTAL.
- RUN:
  - o_step = (i_instruction != HALT_INSTR), combinational from the state register and i_instruction.
  - When i_instruction == HALT_INSTR: o_step=0 in that same cycle; next state DONE.
  - Received bytes are ignored.
- STEP_WAIT:
  - o_step=0.
  - 'N' (8'h4E) → STEP_PULSE.
  - 'E' (8'h45) → IDLE.
  - If i_instruction == HALT_INSTR → DONE; this takes priority over a simultaneous 'N'.
  - Other bytes are ignored.
- STEP_PULSE: o_step=1 for exactly one cycle, then unconditionally → STEP_WAIT.
- DONE: o_halted=1 and o_step=0.
- o_state always reflects the registered state.
- o_instruction_address and o_instruction hold their last values outside the write strobe.

Test Plan:
- Reset with i_reset=0 mid-LOAD after 2 bytes, then release → all outputs 0, state 0, no write strobe.
- Send 'L', then bytes 20,08,00,05, then FF,FF,FF,FF → two single-cycle strobes: (addr 0, 32'h2008_0005) and (addr 4, 32'hFFFF_FFFF); then state IDLE, o_load_error=0.
- Send 'L', then 64 words of 32'h0000_0000 → 64 strobes at addresses 0…252; after the last, o_load_error=1, state IDLE, no strobe at 256.
- Send 'R' with i_instruction=0 for 5 cycles, then set it to FFFF_FFFF → o_step=1 for 5 cycles, 0 in the HALT cycle; next cycle state DONE, o_halted=1. A following 'R' is ignored.
- Send 'S', then 'N' three times spaced 10 cycles apart → exactly three 1-cycle o_step pulses, each one cycle after its 'N'. Then 'E' → IDLE.
- In STEP_WAIT, present 'N' in the same cycle as i_instruction=HALT_INSTR → no o_step pulse; state DONE, o_halted=1.
